// File: rtl/pc_branch_unit.sv
// Registered program counter with conditional jumps and a CALL/RET return-address stack.
// Resolves one flow-control op per stepped cycle; all outputs come straight from flops.
module pc_branch_unit #(
    parameter int unsigned       ADDR_W       = 20,
    parameter int unsigned       STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             step,
    input  logic [2:0]                       op,
    input  logic                             zero_flag,
    input  logic                             carry_flag,
    input  logic                             neg_flag,
    input  logic [ADDR_W-1:0]                target,
    input  logic                             clr_err,
    output logic [ADDR_W-1:0]                pc,
    output logic                             taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_overflow,
    output logic                             stack_underflow
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_JMP   = 3'd1;
    localparam logic [2:0] OP_JMPZ  = 3'd2;
    localparam logic [2:0] OP_JMPNZ = 3'd3;
    localparam logic [2:0] OP_JMPC  = 3'd4;
    localparam logic [2:0] OP_JMPN  = 3'd5;
    localparam logic [2:0] OP_CALL  = 3'd6;
    localparam logic [2:0] OP_RET   = 3'd7;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              taken_q, taken_d;
    logic              stack_overflow_q, stack_overflow_d;
    logic              stack_underflow_q, stack_underflow_d;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] seq_c;
    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic [IDX_W-1:0]  push_idx_c;
    logic [IDX_W-1:0]  top_idx_c;

    assign seq_c      = pc_q + ADDR_W'(1);
    assign full_c     = (sp_q == SP_W'(STACK_DEPTH));
    assign empty_c    = (sp_q == '0);
    assign push_idx_c = IDX_W'(sp_q);
    assign top_idx_c  = IDX_W'(sp_q - SP_W'(1));

    // Next-state resolution of the op; error flags clear unless a new error sets them.
    always_comb begin
        pc_d              = pc_q;
        sp_d              = sp_q;
        taken_d           = 1'b0;
        push_c            = 1'b0;
        stack_overflow_d  = stack_overflow_q & ~clr_err;
        stack_underflow_d = stack_underflow_q & ~clr_err;

        if (step) begin
            pc_d = seq_c;
            case (op)
                OP_NOP: begin
                    pc_d = seq_c;
                end
                OP_JMP: begin
                    pc_d    = target;
                    taken_d = 1'b1;
                end
                OP_JMPZ, OP_JMPNZ, OP_JMPC, OP_JMPN: begin
                    if ((op == OP_JMPZ  &&  zero_flag)  ||
                        (op == OP_JMPNZ && !zero_flag)  ||
                        (op == OP_JMPC  &&  carry_flag) ||
                        (op == OP_JMPN  &&  neg_flag)) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (full_c) begin
                        stack_overflow_d = 1'b1;
                    end else begin
                        push_c  = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty_c) begin
                        stack_underflow_d = 1'b1;
                    end else begin
                        sp_d    = sp_q - SP_W'(1);
                        pc_d    = stack_q[top_idx_c];
                        taken_d = 1'b1;
                    end
                end
                default: begin
                    pc_d = seq_c;
                end
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q              <= RESET_VECTOR;
            sp_q              <= '0;
            taken_q           <= 1'b0;
            stack_overflow_q  <= 1'b0;
            stack_underflow_q <= 1'b0;
        end else begin
            pc_q              <= pc_d;
            sp_q              <= sp_d;
            taken_q           <= taken_d;
            stack_overflow_q  <= stack_overflow_d;
            stack_underflow_q <= stack_underflow_d;
        end
    end

    // Return-address storage; contents only matter below sp, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            stack_q[push_idx_c] <= seq_c;
        end
    end

    assign pc              = pc_q;
    assign taken           = taken_q;
    assign sp              = sp_q;
    assign stack_overflow  = stack_overflow_q;
    assign stack_underflow = stack_underflow_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: vector table for flow ops, hand sequences for stack limits and reset.
module tb_pc_branch_unit;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SP_W   = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JMPZ = 3'd2, JMPNZ = 3'd3;
    localparam logic [2:0] JMPC = 3'd4, JMPN = 3'd5, CALL = 3'd6, RET = 3'd7;

    typedef struct {
        logic              step;
        logic [2:0]        op;
        logic              z, c, n;
        logic [ADDR_W-1:0] tgt;
        logic              clr;
        logic [ADDR_W-1:0] e_pc;
        logic              e_taken;
        logic [SP_W-1:0]   e_sp;
        logic              e_ovf, e_unf;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [SP_W-1:0]   sp;
        logic              ovf, unf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              step;
    logic [2:0]        op;
    logic              zero_flag, carry_flag, neg_flag;
    logic [ADDR_W-1:0] target;
    logic              clr_err;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [SP_W-1:0]   sp;
    logic              stack_overflow, stack_underflow;

    int checks   = 0;
    int failures = 0;

    exp_t              sb[$];
    vec_t              vecs[$];
    logic [ADDR_W-1:0] shadow[$];
    logic [ADDR_W-1:0] m_pc;

    pc_branch_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .op(op),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag),
        .target(target), .clr_err(clr_err), .pc(pc), .taken(taken), .sp(sp),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [2:0] o, input logic z, input logic c,
                                input logic n, input logic [ADDR_W-1:0] t, input logic cl,
                                input logic [ADDR_W-1:0] epc, input logic et,
                                input logic [SP_W-1:0] esp, input logic eo, input logic eu);
        vec_t v;
        v.step = s; v.op = o; v.z = z; v.c = c; v.n = n; v.tgt = t; v.clr = cl;
        v.e_pc = epc; v.e_taken = et; v.e_sp = esp; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, then compare what the DUT produced after the edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e, got;
        step = v.step; op = v.op; zero_flag = v.z; carry_flag = v.c; neg_flag = v.n;
        target = v.tgt; clr_err = v.clr;
        e.pc = v.e_pc; e.taken = v.e_taken; e.sp = v.e_sp; e.ovf = v.e_ovf; e.unf = v.e_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({name, ".pc"}, 32'(pc), 32'(got.pc));
        chk({name, ".taken"}, 32'(taken), 32'(got.taken));
        chk({name, ".sp"}, 32'(sp), 32'(got.sp));
        chk({name, ".ovf"}, 32'(stack_overflow), 32'(got.ovf));
        chk({name, ".unf"}, 32'(stack_underflow), 32'(got.unf));
    endtask

    initial begin
        rst_n = 1'b0; step = 1'b0; op = NOP; zero_flag = 1'b0; carry_flag = 1'b0;
        neg_flag = 1'b0; target = '0; clr_err = 1'b0;

        vecs.push_back(mk(1, NOP,   0, 0, 0, 20'h00000, 0, 20'h00001, 0, 0, 0, 0));
        vecs.push_back(mk(1, NOP,   0, 0, 0, 20'h00000, 0, 20'h00002, 0, 0, 0, 0));
        vecs.push_back(mk(1, NOP,   0, 0, 0, 20'h00000, 0, 20'h00003, 0, 0, 0, 0));
        vecs.push_back(mk(0, NOP,   0, 0, 0, 20'h00000, 0, 20'h00003, 0, 0, 0, 0));
        vecs.push_back(mk(0, JMP,   0, 0, 0, 20'h12345, 0, 20'h00003, 0, 0, 0, 0));
        vecs.push_back(mk(1, JMP,   0, 0, 0, 20'h00010, 0, 20'h00010, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMPZ,  1, 0, 0, 20'hABCDE, 0, 20'hABCDE, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMP,   0, 0, 0, 20'h00010, 0, 20'h00010, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMPZ,  0, 1, 1, 20'hABCDE, 0, 20'h00011, 0, 0, 0, 0));
        vecs.push_back(mk(1, JMPNZ, 0, 0, 0, 20'hABCDE, 0, 20'hABCDE, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMP,   0, 0, 0, 20'h00010, 0, 20'h00010, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMPNZ, 1, 1, 1, 20'hABCDE, 0, 20'h00011, 0, 0, 0, 0));
        vecs.push_back(mk(1, JMPC,  0, 1, 0, 20'hABCDE, 0, 20'hABCDE, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMPC,  1, 0, 1, 20'h55555, 0, 20'hABCDF, 0, 0, 0, 0));
        vecs.push_back(mk(1, JMPN,  0, 0, 1, 20'hABCDE, 0, 20'hABCDE, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMPN,  1, 1, 0, 20'h55555, 0, 20'hABCDF, 0, 0, 0, 0));
        vecs.push_back(mk(1, JMP,   0, 0, 0, 20'hFFFFF, 0, 20'hFFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(1, NOP,   0, 0, 0, 20'h00000, 0, 20'h00000, 0, 0, 0, 0));
        vecs.push_back(mk(1, JMP,   0, 0, 0, 20'hFFFFF, 0, 20'hFFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(1, CALL,  0, 0, 0, 20'h00500, 0, 20'h00500, 1, 1, 0, 0));
        vecs.push_back(mk(1, NOP,   0, 0, 0, 20'h00000, 0, 20'h00501, 0, 1, 0, 0));
        vecs.push_back(mk(1, RET,   0, 0, 0, 20'h77777, 0, 20'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(1, JMP,   0, 0, 0, 20'h00100, 0, 20'h00100, 1, 0, 0, 0));
        vecs.push_back(mk(1, CALL,  0, 0, 0, 20'h00200, 0, 20'h00200, 1, 1, 0, 0));
        vecs.push_back(mk(1, CALL,  0, 0, 0, 20'h00300, 0, 20'h00300, 1, 2, 0, 0));
        vecs.push_back(mk(1, CALL,  0, 0, 0, 20'h00400, 0, 20'h00400, 1, 3, 0, 0));
        vecs.push_back(mk(1, RET,   0, 0, 0, 20'h00000, 0, 20'h00301, 1, 2, 0, 0));
        vecs.push_back(mk(1, RET,   0, 0, 0, 20'h00000, 0, 20'h00201, 1, 1, 0, 0));
        vecs.push_back(mk(1, RET,   0, 0, 0, 20'h00000, 0, 20'h00101, 1, 0, 0, 0));
        vecs.push_back(mk(0, CALL,  0, 0, 0, 20'h00777, 0, 20'h00101, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset.pc", 32'(pc), 32'h0);
        chk("reset.taken", 32'(taken), 32'h0);
        chk("reset.sp", 32'(sp), 32'h0);
        chk("reset.ovf", 32'(stack_overflow), 32'h0);
        chk("reset.unf", 32'(stack_underflow), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Fill the stack, then overflow it.
        m_pc = 20'h00101;
        for (int i = 0; i < DEPTH; i++) begin
            shadow.push_back(m_pc + 20'h1);
            m_pc = 20'h01000 + ADDR_W'(i * 16);
            apply(mk(1, CALL, 0, 0, 0, m_pc, 0, m_pc, 1, SP_W'(i + 1), 0, 0), $sformatf("fill%0d", i));
        end
        m_pc = m_pc + 20'h1;
        apply(mk(1, CALL, 0, 0, 0, 20'h09999, 0, m_pc, 0, SP_W'(DEPTH), 1, 0), "ovf");
        apply(mk(0, NOP, 0, 0, 0, 20'h0, 1, m_pc, 0, SP_W'(DEPTH), 0, 0), "clr_ovf");

        // Drain in LIFO order, then underflow.
        for (int i = 0; i < DEPTH; i++) begin
            m_pc = shadow.pop_back();
            apply(mk(1, RET, 0, 0, 0, 20'h0, 0, m_pc, 1, SP_W'(DEPTH - 1 - i), 0, 0), $sformatf("drain%0d", i));
        end
        m_pc = m_pc + 20'h1;
        apply(mk(1, RET, 0, 0, 0, 20'h0, 0, m_pc, 0, 0, 0, 1), "unf");

        // Refill with underflow still latched, then clear and overflow on the same edge.
        for (int i = 0; i < DEPTH; i++) begin
            shadow.push_back(m_pc + 20'h1);
            m_pc = 20'h02000 + ADDR_W'(i * 32);
            apply(mk(1, CALL, 0, 0, 0, m_pc, 0, m_pc, 1, SP_W'(i + 1), 0, 1), $sformatf("refill%0d", i));
        end
        m_pc = m_pc + 20'h1;
        apply(mk(1, CALL, 0, 0, 0, 20'h03333, 1, m_pc, 0, SP_W'(DEPTH), 1, 0), "clr_and_ovf");
        apply(mk(0, NOP, 0, 0, 0, 20'h0, 1, m_pc, 0, SP_W'(DEPTH), 0, 0), "clr_all");

        for (int i = 0; i < 5; i++) begin
            m_pc = shadow.pop_back();
            apply(mk(1, RET, 0, 0, 0, 20'h0, 0, m_pc, 1, SP_W'(DEPTH - 1 - i), 0, 0), $sformatf("unwind%0d", i));
        end

        // Asynchronous reset between edges with three entries still on the stack.
        step = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async.pc", 32'(pc), 32'h0);
        chk("async.sp", 32'(sp), 32'h0);
        chk("async.taken", 32'(taken), 32'h0);
        rst_n = 1'b1;
        apply(mk(1, RET, 0, 0, 0, 20'h0, 0, 20'h00001, 0, 0, 0, 1), "post_reset_ret");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
